// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
//   Sequential binary-to-BCD converter using iterative double-dabble.
//   One bit of the operand is shifted into the BCD accumulator per clock.
//   A WIDTH-bit operand therefore takes WIDTH cycles in SHIFT, followed by
//   a one-cycle DONE pulse. Only one conversion can be in flight at a time.
//
//   Optional feature macro: BIN2BCD_SIGNED_EN
//     defined     : bin_in is two's complement. Its magnitude is converted,
//                   and neg reports the sign.
//     not defined : bin_in is unsigned and neg is tied low.
//
// Parameters
//   WIDTH   binary operand width in bits (>= 2)
//   DIGITS  number of BCD digits in bcd (digit 0 = ones)
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   conversion request, honoured only in IDLE or DONE
//   bin_in    in   operand, captured on the accepting edge
//   busy      out  high while shifting
//   done      out  one-cycle pulse; bcd/overflow/neg are valid
//   bcd       out  registered BCD result, held until the next done
//   overflow  out  value exceeded 10^DIGITS-1 (bcd = value mod 10^DIGITS)
//   neg       out  sign of the converted operand
// -----------------------------------------------------------------------------
module bin2bcd_seq #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  overflow,
   output logic                  neg
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               w_accept;
   logic               w_last;

   logic [WIDTH-1:0]   r_bin_sh;
   logic [BCD_W-1:0]   r_acc;
   logic               r_ovf;
   logic [CNT_W-1:0]   r_cnt;

   logic [BCD_W-1:0]   r_bcd;
   logic               r_overflow;

   logic [BCD_W-1:0]   w_adj;
   logic [BCD_W-1:0]   w_acc_nxt;
   logic               w_ovf_nxt;
   logic [WIDTH-1:0]   w_operand;

   // Double-dabble pre-adjust: any digit of 5 or more gets +3, so that the
   // following left shift carries correctly into the next decade.
   function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] acc);
      logic [BCD_W-1:0] res;
      res = acc;
      for (int d = 0; d < DIGITS; d++) begin
         if (acc[4*d +: 4] >= 4'd5) res[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      end
      return res;
   endfunction

`ifdef BIN2BCD_SIGNED_EN
   // The negation wraps for the most negative value. The result is then
   // read as unsigned, which gives 2^(WIDTH-1) as required.
   function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
      logic signed [WIDTH-1:0] n;
      n = -v;
      return v[WIDTH-1] ? $unsigned(n) : $unsigned(v);
   endfunction

   logic r_neg_cap;
   logic r_neg;

   assign w_operand = magnitude(bin_in);
   assign neg       = r_neg;
`else
   assign w_operand = bin_in;
   assign neg       = 1'b0;
`endif

   assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
   assign w_adj     = dd_adjust(r_acc);
   // {ovf_sticky, acc, bin_sh} shifted left by one as a single vector.
   assign w_acc_nxt = {w_adj[BCD_W-2:0], r_bin_sh[WIDTH-1]};
   assign w_ovf_nxt = r_ovf | w_adj[BCD_W-1];

   // -------------------------------------------------------------------------
   // FSM state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (w_last) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            // start in the DONE cycle begins the next conversion directly.
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = S_SHIFT;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // Shift datapath and result registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bin_sh   <= '0;
         r_acc      <= '0;
         r_ovf      <= 1'b0;
         r_cnt      <= '0;
         r_bcd      <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_accept) begin
            r_bin_sh <= w_operand;
            r_acc    <= '0;
            r_ovf    <= 1'b0;
            r_cnt    <= '0;
         end else if (r_state == S_SHIFT) begin
            r_bin_sh <= r_bin_sh << 1;
            r_acc    <= w_acc_nxt;
            r_ovf    <= w_ovf_nxt;
            r_cnt    <= r_cnt + CNT_W'(1);
         end
         // The result is published from the final shift. The accumulator
         // itself is never driven onto the outputs.
         if (r_state == S_SHIFT && w_last) begin
            r_bcd      <= w_acc_nxt;
            r_overflow <= w_ovf_nxt;
         end
      end
   end

`ifdef BIN2BCD_SIGNED_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_neg_cap <= 1'b0;
         r_neg     <= 1'b0;
      end else begin
         if (w_accept)                    r_neg_cap <= bin_in[WIDTH-1];
         if (r_state == S_SHIFT && w_last) r_neg     <= r_neg_cap;
      end
   end
`endif

   assign busy     = (r_state == S_SHIFT);
   assign done     = (r_state == S_DONE);
   assign bcd      = r_bcd;
   assign overflow = r_overflow;

endmodule
